// File: rtl/spike_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spike_stream_arbiter
// Description : Merges N_SRC spike streams into a single stream. Each source
//               has its own FIFO. The start markers (F1FA) and end markers
//               (FAF1) of all sources are aligned, so each timestep produces
//               exactly one merged frame. Spikes are interleaved round-robin.
//               Optional build macro SPIKE_ARB_OFFSET_EN adds
//               src*NEURONS_PER_SRC to each forwarded spike index.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_stream_arbiter #(
  parameter int N_SRC           = 2,
  parameter int DATA_W          = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int NEURONS_PER_SRC = 256,
  parameter int TIMESTEPS       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC*DATA_W-1:0] in_data,
  input  logic [N_SRC-1:0]        in_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              timestep,
  output logic [N_SRC-1:0]        overflow,
  output logic                    proto_err
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [DATA_W-1:0] c_MARK_START = DATA_W'(16'hF1FA);
  localparam logic [DATA_W-1:0] c_MARK_END   = DATA_W'(16'hFAF1);

`ifdef SPIKE_ARB_OFFSET_EN
  localparam logic c_OFFSET_EN = 1'b1;
`else
  localparam logic c_OFFSET_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_WAIT_START = 2'd0,
    S_EMIT_START = 2'd1,
    S_STREAM     = 2'd2,
    S_EMIT_END   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        timestep_q, timestep_d;
  logic [N_SRC-1:0]  overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;
  logic [SRC_W-1:0]  rr_q, rr_d;

  // FIFO status and head words, one per source
  logic [DATA_W-1:0] head [N_SRC];
  logic [N_SRC-1:0]  empty;
  logic [N_SRC-1:0]  full;
  logic [N_SRC-1:0]  pop;

  // Head classification and arbitration results
  logic [N_SRC-1:0]  is_start;
  logic [N_SRC-1:0]  is_end;
  logic [N_SRC-1:0]  is_spike;
  logic              found;
  logic [SRC_W-1:0]  grant;
  int                cand;
  logic              load_en;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] offset;

  // --------------------------------------------------------------------------
  // Per-source FIFOs. A push onto a full FIFO is still accepted when the same
  // FIFO is being popped in that cycle, since a slot frees up at the edge.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              push;

    assign empty[gi] = (wr_ptr_q == rd_ptr_q);
    assign full[gi]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head[gi]  = mem_q[rd_ptr_q[AW-1:0]];
    assign push      = in_valid[gi] && (!full[gi] || pop[gi]);

    // Pointer advance on push/pop
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push)    wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop[gi]) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage write; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data[gi*DATA_W +: DATA_W];
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM, round-robin arbiter and output register next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timestep_d  = timestep_q;
    proto_err_d = proto_err_q;
    rr_d        = rr_q;
    pop         = '0;
    load        = 1'b0;
    load_word   = '0;
    found       = 1'b0;
    grant       = '0;
    cand        = 0;
    is_start    = '0;
    is_end      = '0;
    is_spike    = '0;

    // The output register may take a new word when empty or being drained
    load_en = !out_valid_q || out_ready;

    for (int i = 0; i < N_SRC; i++) begin
      is_start[i] = !empty[i] && (head[i] == c_MARK_START);
      is_end[i]   = !empty[i] && (head[i] == c_MARK_END);
      is_spike[i] = !empty[i] && (head[i] != c_MARK_START) && (head[i] != c_MARK_END);
    end

    // First source holding a spike at or after the round-robin pointer
    for (int k = 0; k < N_SRC; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!found && is_spike[cand]) begin
        found = 1'b1;
        grant = SRC_W'(cand);
      end
    end

    offset = c_OFFSET_EN ? DATA_W'(int'(grant) * NEURONS_PER_SRC) : '0;

    case (state_q)
      S_WAIT_START: begin
        if (&is_start) begin
          pop     = '1;
          state_d = S_EMIT_START;
        end else begin
          // Anything other than a start marker here is out of protocol
          pop = is_spike | is_end;
          if (|pop) proto_err_d = 1'b1;
        end
      end

      S_EMIT_START: begin
        if (load_en) begin
          load      = 1'b1;
          load_word = c_MARK_START;
          state_d   = S_STREAM;
        end
      end

      S_STREAM: begin
        // A stray start marker mid-frame is discarded
        pop = is_start;
        if (|is_start) proto_err_d = 1'b1;
        if (load_en && found) begin
          pop[grant] = 1'b1;
          load       = 1'b1;
          load_word  = head[grant] + offset;
          rr_d       = (grant == SRC_W'(N_SRC-1)) ? '0 : grant + SRC_W'(1);
        end else if (&is_end) begin
          pop     = '1;
          state_d = S_EMIT_END;
        end
      end

      S_EMIT_END: begin
        if (load_en) begin
          load       = 1'b1;
          load_word  = c_MARK_END;
          timestep_d = (timestep_q == 4'(TIMESTEPS-1)) ? 4'd0 : timestep_q + 4'd1;
          state_d    = S_WAIT_START;
        end
      end

      default: state_d = S_WAIT_START;
    endcase

    if (load_en) begin
      out_valid_d = load;
      if (load) out_data_d = load_word;
    end

    overflow_d = overflow_q | (in_valid & full & ~pop);
  end

  // State, output and sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_START;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      timestep_q  <= 4'd0;
      overflow_q  <= '0;
      proto_err_q <= 1'b0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      timestep_q  <= timestep_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      rr_q        <= rr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign timestep  = timestep_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spike_stream_arbiter
// Description : Directed self-checking bench for spike_stream_arbiter with
//               N_SRC=2. Expected values are hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_stream_arbiter;

  localparam logic [15:0] c_S = 16'hF1FA;
  localparam logic [15:0] c_E = 16'hFAF1;
`ifdef SPIKE_ARB_OFFSET_EN
  localparam logic [15:0] c_OFF1 = 16'd256;
`else
  localparam logic [15:0] c_OFF1 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  in_valid = '0;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  timestep;
  logic [1:0]  overflow;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  spike_stream_arbiter #(
    .N_SRC(2), .DATA_W(16), .FIFO_DEPTH(16), .NEURONS_PER_SRC(256), .TIMESTEPS(8)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .timestep(timestep), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [15:0] w0, input logic [15:0] w1);
    in_valid = v;
    in_data  = {w1, w0};
    tick();
    in_valid = '0;
  endtask

  // Wait (bounded) for a valid word, compare it, and let it be accepted
  task automatic expect_word(input string tag, input logic [15:0] exp);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    if (out_valid !== 1'b1) check({tag, "_valid"}, {15'b0, out_valid}, 16'd1);
    else                    check(tag, out_data, exp);
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check(tag, {15'b0, out_valid}, 16'd1);
  endtask

  task automatic minimal_frame(input string tag);
    out_ready = 1'b0;
    push(2'b11, c_S, c_S);
    push(2'b11, c_E, c_E);
    out_ready = 1'b1;
    expect_word({tag, "_start"}, c_S);
    expect_word({tag, "_end"}, c_E);
  endtask

  initial begin
    logic saw_valid;

    // ---------------- Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_out_data",  out_data, 16'd0);
    check("rst_timestep",  {12'b0, timestep}, 16'd0);
    check("rst_overflow",  {14'b0, overflow}, 16'd0);
    check("rst_proto_err", {15'b0, proto_err}, 16'd0);

    // ---------------- Basic merge: {3,7} and {5}, pointer starts at 0
    out_ready = 1'b0;
    push(2'b11, c_S, c_S);
    push(2'b11, 16'd3, 16'd5);
    push(2'b11, 16'd7, c_E);
    push(2'b01, c_E, 16'd0);
    out_ready = 1'b1;
    expect_word("t1_start", c_S);
    expect_word("t1_w0", 16'd3);
    expect_word("t1_w1", 16'd5 + c_OFF1);
    expect_word("t1_w2", 16'd7);
    expect_word("t1_end", c_E);
    check("t1_timestep", {12'b0, timestep}, 16'd1);

    // ---------------- Start alignment: source1 start arrives late
    out_ready = 1'b0;
    push(2'b01, c_S, 16'd0);
    push(2'b01, 16'd12, 16'd0);
    push(2'b01, c_E, 16'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("t2_no_early_out", {15'b0, saw_valid}, 16'd0);
    push(2'b10, 16'd0, c_S);
    push(2'b10, 16'd0, c_E);
    out_ready = 1'b1;
    expect_word("t2_start", c_S);
    expect_word("t2_w0", 16'd12);
    expect_word("t2_end", c_E);
    check("t2_timestep", {12'b0, timestep}, 16'd2);
    check("t2_proto_err", {15'b0, proto_err}, 16'd0);

    // ---------------- Backpressure: output held, pointer is now at source 1
    out_ready = 1'b0;
    push(2'b11, c_S, c_S);
    push(2'b11, 16'd20, 16'd30);
    push(2'b01, 16'd21, 16'd0);
    push(2'b11, c_E, c_E);
    wait_valid("t4_valid");
    check("t4_hold_data0", out_data, c_S);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_data", out_data, c_S);
      check("t4_hold_valid", {15'b0, out_valid}, 16'd1);
    end
    out_ready = 1'b1;
    expect_word("t4_start", c_S);
    expect_word("t4_w0", 16'd30 + c_OFF1);
    expect_word("t4_w1", 16'd20);
    expect_word("t4_w2", 16'd21);
    expect_word("t4_end", c_E);
    check("t4_timestep", {12'b0, timestep}, 16'd3);

    // ---------------- Overflow: 17 words into source0 while it waits
    out_ready = 1'b0;
    push(2'b01, c_S, 16'd0);
    for (int i = 0; i < 15; i++) push(2'b01, 16'(100 + i), 16'd0);
    push(2'b01, 16'd115, 16'd0);
    check("t3_overflow", {14'b0, overflow}, 16'd1);
    push(2'b10, 16'd0, c_S);
    push(2'b10, 16'd0, c_E);
    push(2'b01, c_E, 16'd0);
    out_ready = 1'b1;
    expect_word("t3_start", c_S);
    for (int i = 0; i < 15; i++) expect_word("t3_spike", 16'(100 + i));
    expect_word("t3_end", c_E);
    check("t3_timestep", {12'b0, timestep}, 16'd4);

    // ---------------- Protocol error and timestep wrap
    push(2'b01, 16'd9, 16'd0);
    tick(); tick();
    check("t5_proto_err", {15'b0, proto_err}, 16'd1);
    minimal_frame("t5_f0");
    check("t5_ts_5", {12'b0, timestep}, 16'd5);
    minimal_frame("t5_f1");
    check("t5_ts_6", {12'b0, timestep}, 16'd6);
    minimal_frame("t5_f2");
    check("t5_ts_7", {12'b0, timestep}, 16'd7);
    minimal_frame("t5_f3");
    check("t5_ts_wrap", {12'b0, timestep}, 16'd0);

    // ---------------- Reset mid-stream with 4 queued spikes
    out_ready = 1'b0;
    push(2'b11, c_S, c_S);
    push(2'b11, 16'd40, 16'd50);
    push(2'b11, 16'd41, 16'd51);
    wait_valid("t6_valid");
    tick(); tick();
    check("t6_stalled_data", out_data, c_S);
    rst = 1'b1;
    tick();
    check("t6_rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("t6_rst_out_data", out_data, 16'd0);
    check("t6_rst_proto_err", {15'b0, proto_err}, 16'd0);
    check("t6_rst_overflow", {14'b0, overflow}, 16'd0);
    check("t6_rst_timestep", {12'b0, timestep}, 16'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("t6_fifo_flushed", {15'b0, saw_valid}, 16'd0);
    minimal_frame("t6_frame");
    check("t6_timestep", {12'b0, timestep}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
